// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: access size codes, requester ids,
// response record layout and the alignment rule applied to data accesses.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    RID_NONE = 2'd0,
    RID_IF   = 2'd1,
    RID_D    = 2'd2
  } rid_t;

  // Everything the response cycle needs to know about the access granted one cycle earlier
  typedef struct packed {
    rid_t       id;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } resp_t;

  localparam resp_t RESP_IDLE = '{id: RID_NONE, we: 1'b0, size: SZ_B, uns: 1'b0, err: 1'b0};

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the port arbiter.
// The arbiter takes the slave view; requesters plus the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_wena;
  logic              mem_ba;
  logic              mem_ha;
  logic              mem_ua;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_wena, mem_ba, mem_ha, mem_ua, mem_addr, mem_din,
    output mem_dout
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_wena, mem_ba, mem_ha, mem_ua, mem_addr, mem_din,
    input  mem_dout
  );

endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// Combinational load formatter: picks the byte/half/word out of a right-justified
// raw memory word and sign- or zero-extends it to the full data width.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  logic fill_b;
  logic fill_h;

  assign fill_b = ~uns & raw[7];
  assign fill_h = ~uns & raw[15];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      if (gi < 8) begin : g_low
        assign ext[gi] = raw[gi];
      end else if (gi < 16) begin : g_mid
        assign ext[gi] = (size == SZ_B) ? fill_b : raw[gi];
      end else begin : g_high
        assign ext[gi] = (size == SZ_B) ? fill_b :
                         (size == SZ_H) ? fill_h : raw[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter between instruction fetch and load/store.
// Data normally wins; fetch is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [CNT_W-1:0]  starve_cnt_reg;
  resp_t             resp_reg;
  resp_t             resp_next;
  logic              sel_if;
  logic              sel_d;
  logic              d_misaligned;
  logic [DATA_W-1:0] ext_data;

  assign d_misaligned = is_misaligned(bus.d_size, bus.d_addr[1:0]);

  // Grants are combinational on the request and held off entirely while in reset
  always_comb begin
    sel_if = 1'b0;
    sel_d  = 1'b0;
    if (!rst) begin
      if (bus.d_req && !(bus.if_req && (starve_cnt_reg == CNT_MAX))) begin
        sel_d = 1'b1;
      end else if (bus.if_req) begin
        sel_if = 1'b1;
      end
    end
  end

  assign bus.if_gnt = sel_if;
  assign bus.d_gnt  = sel_d;

  always_comb begin
    bus.mem_wena = 1'b0;
    bus.mem_ba   = 1'b0;
    bus.mem_ha   = 1'b0;
    bus.mem_ua   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (sel_if) begin
      bus.mem_addr = bus.if_addr & WORD_MASK;
    end else if (sel_d) begin
      // A misaligned access still occupies the slot but must never write
      bus.mem_wena = bus.d_we & ~d_misaligned;
      bus.mem_ba   = (bus.d_size == SZ_B);
      bus.mem_ha   = (bus.d_size == SZ_H);
      bus.mem_ua   = bus.d_unsigned;
      bus.mem_addr = bus.d_addr;
      bus.mem_din  = bus.d_wdata;
    end
  end

  always_comb begin
    resp_next = RESP_IDLE;
    if (sel_if) begin
      resp_next.id = RID_IF;
    end else if (sel_d) begin
      resp_next.id   = RID_D;
      resp_next.we   = bus.d_we;
      resp_next.size = bus.d_size;
      resp_next.uns  = bus.d_unsigned;
      resp_next.err  = d_misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_reg       <= RESP_IDLE;
      starve_cnt_reg <= '0;
    end else begin
      resp_reg <= resp_next;
      if (!bus.if_req || sel_if) begin
        starve_cnt_reg <= '0;
      end else if (sel_d && (starve_cnt_reg != CNT_MAX)) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .size(resp_reg.size),
    .uns (resp_reg.uns),
    .raw (bus.mem_dout),
    .ext (ext_data)
  );

  // Response side is driven purely from the registered record, so reset zeroes it
  assign bus.if_rvalid = (resp_reg.id == RID_IF);
  assign bus.d_rvalid  = (resp_reg.id == RID_D);
  assign bus.d_err     = bus.d_rvalid & resp_reg.err;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_dout : '0;
  assign bus.d_rdata   = (bus.d_rvalid && !resp_reg.err && !resp_reg.we) ? ext_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a byte-addressed memory model and
// a response scoreboard; one line per transaction.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int OUT_W      = 115;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory model: little-endian bytes, registered read right-justified by access size
  logic [7:0]        mem [1024];
  logic [ADDR_W-1:0] ma0, ma1, ma2, ma3;
  assign ma0 = bus.mem_addr;
  assign ma1 = bus.mem_addr + 10'd1;
  assign ma2 = bus.mem_addr + 10'd2;
  assign ma3 = bus.mem_addr + 10'd3;

  always @(posedge clk) begin
    if (bus.mem_wena === 1'b1) begin
      mem[ma0] <= bus.mem_din[7:0];
      if (!bus.mem_ba) mem[ma1] <= bus.mem_din[15:8];
      if (!bus.mem_ba && !bus.mem_ha) begin
        mem[ma2] <= bus.mem_din[23:16];
        mem[ma3] <= bus.mem_din[31:24];
      end
    end
    if (bus.mem_ba)      bus.mem_dout <= {24'h0, mem[ma0]};
    else if (bus.mem_ha) bus.mem_dout <= {16'h0, mem[ma1], mem[ma0]};
    else                 bus.mem_dout <= {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wena_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_wena === 1'b1) wena_cnt++;
    if (bus.if_gnt === 1'b1 && bus.d_gnt === 1'b1) both_cnt++;
  end

  typedef struct {
    logic        is_if;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } acc_t;

  function automatic logic [OUT_W-1:0] all_outs();
    return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
            bus.d_err, bus.mem_wena, bus.mem_ba, bus.mem_ha, bus.mem_ua, bus.mem_addr, bus.mem_din};
  endfunction

  // Drives one data request from posedge+1 and returns at posedge+1 after the grant edge
  task automatic d_issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata, output logic granted);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_unsigned = uns;
    bus.d_addr = addr; bus.d_wdata = wdata;
    granted = 1'b0;
    for (int i = 0; i < 8 && !granted; i++) begin
      @(negedge clk);
      granted = bus.d_gnt;
      @(posedge clk);
      #1;
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = '1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = SZ_W; bus.d_unsigned = 1'b1;
    bus.d_addr = 10'h004; bus.d_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end else $display("reset: all outputs 0 with requests asserted");
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end else $display("reset released: idle outputs 0");
  endtask

  task automatic test_data_access();
    acc_t  tbl[$];
    exp_t  e;
    logic  granted;
    int    snap;
    tbl.push_back(acc_t'{1'b1, SZ_W, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0000_0000});
    tbl.push_back(acc_t'{1'b0, SZ_W, 1'b0, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back(acc_t'{1'b0, SZ_B, 1'b0, 10'h010, 32'h0,        1'b0, 32'hFFFF_FFEF});
    tbl.push_back(acc_t'{1'b0, SZ_B, 1'b1, 10'h010, 32'h0,        1'b0, 32'h0000_00EF});
    tbl.push_back(acc_t'{1'b0, SZ_H, 1'b0, 10'h010, 32'h0,        1'b0, 32'hFFFF_BEEF});
    tbl.push_back(acc_t'{1'b0, SZ_H, 1'b1, 10'h012, 32'h0,        1'b0, 32'h0000_DEAD});
    tbl.push_back(acc_t'{1'b0, SZ_H, 1'b0, 10'h012, 32'h0,        1'b0, 32'hFFFF_DEAD});
    tbl.push_back(acc_t'{1'b0, SZ_B, 1'b0, 10'h013, 32'h0,        1'b0, 32'hFFFF_FFDE});
    tbl.push_back(acc_t'{1'b0, SZ_W, 1'b0, 10'h012, 32'h0,        1'b1, 32'h0000_0000});
    tbl.push_back(acc_t'{1'b1, SZ_H, 1'b0, 10'h011, 32'h0000_1234, 1'b1, 32'h0000_0000});
    tbl.push_back(acc_t'{1'b1, 2'b11, 1'b0, 10'h010, 32'h0000_5555, 1'b1, 32'h0000_0000});
    tbl.push_back(acc_t'{1'b0, SZ_W, 1'b0, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back(acc_t'{1'b1, SZ_H, 1'b0, 10'h014, 32'hAAAA_8001, 1'b0, 32'h0000_0000});
    tbl.push_back(acc_t'{1'b0, SZ_H, 1'b0, 10'h014, 32'h0,        1'b0, 32'hFFFF_8001});
    tbl.push_back(acc_t'{1'b0, SZ_W, 1'b1, 10'h014, 32'h0,        1'b0, 32'h0000_8001});
    foreach (tbl[i]) begin
      snap = wena_cnt;
      sb.push_back(exp_t'{1'b0, tbl[i].err, tbl[i].rdata});
      d_issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, granted);
      n_checks++;
      if (granted !== 1'b1) begin
        n_fail++;
        $display("FAIL d_gnt_timeout[%0d]: got no grant expected grant", i);
      end
      e = sb.pop_front();
      n_checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_err !== e.err || bus.d_rdata !== e.data) begin
        n_fail++;
        $display("FAIL data_resp[%0d]: got rvalid=%b err=%b rdata=%h expected rvalid=1 err=%b rdata=%h",
                 i, bus.d_rvalid, bus.d_err, bus.d_rdata, e.err, e.data);
      end else
        $display("data[%0d] we=%b size=%b uns=%b addr=%h: err=%b rdata=%h", i, tbl[i].we,
                 tbl[i].size, tbl[i].uns, tbl[i].addr, bus.d_err, bus.d_rdata);
      if (e.err) begin
        n_checks++;
        if (wena_cnt !== snap) begin
          n_fail++;
          $display("FAIL misaligned_no_write[%0d]: got %0d write cycles expected 0", i, wena_cnt - snap);
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_resp: got rvalid=%b rdata=%h expected rvalid=0 rdata=0", bus.d_rvalid, bus.d_rdata);
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    logic exp_if;
    int   both_snap;
    both_snap = both_cnt;
    bus.if_addr = 10'h040; bus.if_req = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_unsigned = 1'b0; bus.d_addr = 10'h010;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_if = (k % 5 == 4);
      n_checks++;
      if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) begin
        n_fail++;
        $display("FAIL starve_gnt[%0d]: got if_gnt=%b d_gnt=%b expected if_gnt=%b d_gnt=%b",
                 k, bus.if_gnt, bus.d_gnt, exp_if, !exp_if);
      end
      sb.push_back(exp_t'{exp_if, 1'b0, exp_if ? 32'h0 : 32'hDEADBEEF});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.if_rvalid !== e.is_if || bus.d_rvalid !== !e.is_if ||
          (e.is_if ? bus.if_rdata : bus.d_rdata) !== e.data) begin
        n_fail++;
        $display("FAIL starve_resp[%0d]: got if_rvalid=%b d_rvalid=%b if_rdata=%h d_rdata=%h expected is_if=%b data=%h",
                 k, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata, e.is_if, e.data);
      end else
        $display("starve cycle %0d: winner=%s", k, e.is_if ? "fetch" : "data");
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_checks++;
    if (both_cnt !== both_snap) begin
      n_fail++;
      $display("FAIL single_grant: got %0d dual-grant cycles expected 0", both_cnt - both_snap);
    end
  endtask

  task automatic test_fetch_after_store();
    exp_t e;
    logic granted;
    logic [9:0] seen_addr;
    sb.push_back(exp_t'{1'b0, 1'b0, 32'h0});
    d_issue(1'b1, SZ_B, 1'b0, 10'h020, 32'h0000_005A, granted);
    e = sb.pop_front();
    n_checks++;
    if (granted !== 1'b1 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== e.data) begin
      n_fail++;
      $display("FAIL store_byte: got gnt=%b rvalid=%b rdata=%h expected gnt=1 rvalid=1 rdata=%h",
               granted, bus.d_rvalid, bus.d_rdata, e.data);
    end
    bus.if_req = 1'b1; bus.if_addr = 10'h022;
    granted = 1'b0;
    seen_addr = '0;
    for (int i = 0; i < 8 && !granted; i++) begin
      @(negedge clk);
      granted = bus.if_gnt;
      seen_addr = bus.mem_addr;
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0;
    n_checks++;
    if (granted !== 1'b1 || seen_addr !== 10'h020) begin
      n_fail++;
      $display("FAIL fetch_gnt: got gnt=%b mem_addr=%h expected gnt=1 mem_addr=020", granted, seen_addr);
    end
    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0000_005A});
    e = sb.pop_front();
    n_checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL fetch_data: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
               bus.if_rvalid, bus.if_rdata, e.data);
    end else
      $display("fetch @022 after byte store: if_rdata=%h", bus.if_rdata);
  endtask

  task automatic test_reset_mid_load();
    logic granted;
    int   stray;
    d_issue(1'b0, SZ_W, 1'b0, 10'h010, 32'h0, granted);
    n_checks++;
    if (granted !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_gnt: got no grant expected grant");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0", all_outs());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL dropped_resp: got %0d rvalid cycles expected 0", stray);
    end else $display("reset after load grant: response dropped");
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_B; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_data_access();
    test_starvation();
    test_fetch_after_store();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port byte-addressed data memory (1 KiB, byte/half/word access, 1-cycle registered read) between the instruction-fetch requester and the load/store requester. It selects one request per cycle and drives the memory's write-enable, size and address controls. It returns load data sign- or zero-extended and rejects misaligned data accesses without touching memory. It sits between the core's IF/MEM stages and the memory instance.

## Interface
- ADDR_W, 10, byte address width (memory depth 2^ADDR_W bytes)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (forced 00)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held with all d_* inputs until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned
- d_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data, right-justified
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (cycle after d_gnt), loads and stores
- d_rdata  out  DATA_W  extended load data; 0 for stores and errors
- d_err  out  1  qualifies d_rvalid: access was misaligned, not performed
- mem_wena, mem_ba, mem_ha, mem_ua  out  1 each  memory write-enable, byte, half, unsigned controls
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory registered read data, valid cycle after address applied

## Operation
- Arbitration (combinational, this cycle): only d_req → data; only if_req → fetch; both → data, unless starve_cnt == STARVE_MAX, then fetch.
- starve_cnt: +1 each cycle if_req is high and data wins; cleared on if_gnt or when if_req low; saturates at STARVE_MAX.
- Fetch grant: mem_wena=0, mem_ba=mem_ha=0, mem_addr={if_addr[ADDR_W-1:2],2'b00}.
- Data grant, aligned: mem_wena=d_we, mem_ba=(size==00), mem_ha=(size==01), mem_ua=d_unsigned, mem_addr=d_addr, mem_din=d_wdata.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00; size 11. Still granted; mem_wena forced 0; response d_err=1, d_rdata=0.
- Response register: {resp_id (NONE/IF/D), resp_size, resp_unsigned, resp_err}, loaded on grant, cleared when idle.
- Load extension: byte → mem_dout[7:0], half → mem_dout[15:0], word → full; sign or zero per resp_unsigned.
- No cycle without a grant drives mem_wena=1; idle cycles drive all mem_* controls 0.

## Timing
- Reset: all outputs 0; starve_cnt=0; resp_id=NONE. Reset mid-transaction drops the pending response (no rvalid after release).
- Grant is same-cycle (Mealy) on req; exactly one of if_gnt/d_gnt per cycle at most.
- rvalid exactly 1 cycle after gnt; back-to-back grants allowed, throughput 1 access/cycle.
- Store commits at the rising edge ending the d_gnt cycle. A load granted the next cycle to the same address returns the new data.
- Simultaneous requests every cycle: fetch guaranteed a grant at least once per STARVE_MAX+1 cycles.
- Requester dropping req before gnt: undefined, not checked.

## Structure
- Shared package mem_pkg: size encodings SZ_B/SZ_H/SZ_W, requester id enum (RID_NONE, RID_IF, RID_D), misalign check function.
- Sub-module load_extend (combinational: size, unsigned, raw word → extended word), reused by later MMIO path.
- Arbiter, starvation counter and response register in the top module.

## Test plan
- Store word 0xDEADBEEF @0x010, then load word @0x010 → d_rvalid next cycle after grant, d_rdata=0xDEADBEEF, d_err=0.
- Load byte @0x010 signed → 0xFFFFFFEF; unsigned → 0x000000EF; half signed → 0xFFFFBEEF.
- Load word @0x012 → d_gnt, d_rvalid with d_err=1, d_rdata=0, mem_wena never 1; store half @0x011 → memory unchanged.
- if_req and d_req held high 20 cycles, STARVE_MAX=4 → if_gnt every 5th cycle, d_gnt otherwise, never both.
- Store byte 0x5A @0x020 then immediate fetch @0x020 → if_rdata[7:0]=0x5A.
- Assert rst the cycle after d_gnt on a load → no d_rvalid; all outputs 0 during reset.
